// File: rtl/grid_serial_host.sv
// Host-side driver for the grid memory's serial link: turns load/step/read
// commands into LOAD_MODE/RUN_MODE/OUTPUT_MODE pin sequences and returns one response per command.
module grid_serial_host #(
  parameter int data_size  = 64,
  parameter int step_width = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [1:0]            CMD_OP,
  input  logic [data_size-1:0]  CMD_DATA,
  input  logic [step_width-1:0] CMD_STEPS,
  output logic                  RSP_VALID,
  output logic                  RSP_ERR,
  output logic [data_size-1:0]  RSP_DATA,
  output logic                  SERIAL_TX,
  input  logic                  SERIAL_RX,
  output logic                  LOAD_MODE,
  output logic                  RUN_MODE,
  output logic                  OUTPUT_MODE,
  output logic [2:0]            DBG_STATE
);

  // Handshake: a command transfers on a rising CLK edge where CMD_VALID and
  // CMD_READY are both high; CMD_READY is high only while idle, and the
  // response is a single RSP_VALID pulse that the consumer cannot stall.

  localparam int BIT_W = $clog2(data_size + 1);
  localparam int CNT_W = (step_width > BIT_W) ? step_width : BIT_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_STEP = 3'd2;
  localparam logic [2:0] S_READ = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;

  localparam logic [CNT_W-1:0] C_ZERO     = '0;
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(data_size - 1);
  localparam logic [CNT_W-1:0] C_ALL_BITS = CNT_W'(data_size);

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [data_size-1:0] r_shift;
  logic [data_size-1:0] r_cap;
  logic                 r_cmd_ready;
  logic                 r_rsp_valid;
  logic                 r_rsp_err;
  logic [data_size-1:0] r_rsp_data;
  logic                 r_tx;
  logic                 r_load_mode;
  logic                 r_run_mode;
  logic                 r_output_mode;

  logic                 w_accept;
  logic [data_size-1:0] w_cap_next;

  assign w_accept   = CMD_VALID & r_cmd_ready;
  assign w_cap_next = {r_cap[data_size-2:0], SERIAL_RX};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_cap         <= '0;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_data    <= '0;
      r_tx          <= 1'b0;
      r_load_mode   <= 1'b0;
      r_run_mode    <= 1'b0;
      r_output_mode <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            case (CMD_OP)
              OP_LOAD: begin
                // First bit goes out in the cycle right after accept, MSB first.
                r_state     <= S_LOAD;
                r_load_mode <= 1'b1;
                r_tx        <= CMD_DATA[data_size-1];
                r_shift     <= CMD_DATA << 1;
                r_cnt       <= C_LAST_BIT;
              end
              OP_STEP: begin
                if (CMD_STEPS == '0) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                end else begin
                  r_state    <= S_STEP;
                  r_run_mode <= 1'b1;
                  r_cnt      <= CNT_W'(CMD_STEPS) - C_ONE;
                end
              end
              OP_READ: begin
                r_state       <= S_READ;
                r_output_mode <= 1'b1;
                r_cnt         <= C_ALL_BITS;
              end
              default: begin
                r_state     <= S_RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
              end
            endcase
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        S_LOAD: begin
          if (r_cnt == C_ZERO) begin
            r_state     <= S_RESP;
            r_load_mode <= 1'b0;
            r_tx        <= 1'b0;
            r_rsp_valid <= 1'b1;
          end else begin
            r_tx    <= r_shift[data_size-1];
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt - C_ONE;
          end
        end

        S_STEP: begin
          if (r_cnt == C_ZERO) begin
            r_state     <= S_RESP;
            r_run_mode  <= 1'b0;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end

        S_READ: begin
          // SERIAL_RX trails OUTPUT_MODE by a cycle, so sampling starts one
          // edge late and runs one edge past the last OUTPUT_MODE cycle.
          if (r_cnt != C_ALL_BITS) begin
            r_cap <= w_cap_next;
          end
          if (r_cnt == C_ONE) begin
            r_output_mode <= 1'b0;
          end
          if (r_cnt == C_ZERO) begin
            r_state     <= S_RESP;
            r_rsp_data  <= w_cap_next;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end

        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_cmd_ready <= 1'b1;
        end

        default: begin
          r_state       <= S_IDLE;
          r_cmd_ready   <= 1'b0;
          r_rsp_valid   <= 1'b0;
          r_rsp_err     <= 1'b0;
          r_tx          <= 1'b0;
          r_load_mode   <= 1'b0;
          r_run_mode    <= 1'b0;
          r_output_mode <= 1'b0;
        end
      endcase
    end
  end

  assign CMD_READY   = r_cmd_ready;
  assign RSP_VALID   = r_rsp_valid;
  assign RSP_ERR     = r_rsp_err;
  assign RSP_DATA    = r_rsp_data;
  assign SERIAL_TX   = r_tx;
  assign LOAD_MODE   = r_load_mode;
  assign RUN_MODE    = r_run_mode;
  assign OUTPUT_MODE = r_output_mode;
  assign DBG_STATE   = r_state;

endmodule

// File: tb/tb_grid_serial_host.sv
// Bench for grid_serial_host: an 8-bit and a 64-bit host, each wired to a
// simple serial memory; command-level expectations come from a grid model.
module tb_grid_serial_host;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  bit          sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [63:0] cmd_data = '0;
  logic [15:0] cmd_steps = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic        ready8, rsp_valid8, rsp_err8, tx8, rx8, load8, run8, out8;
  logic [7:0]  rsp_data8;
  logic [2:0]  dbg8;
  logic        ready64, rsp_valid64, rsp_err64, tx64, rx64, load64, run64, out64;
  logic [63:0] rsp_data64;
  logic [2:0]  dbg64;

  always #5 clk = ~clk;

  grid_serial_host #(.data_size(8), .step_width(16)) dut8 (
    .CLK(clk), .RESET(reset), .CMD_VALID(cmd_valid & ~sel), .CMD_READY(ready8),
    .CMD_OP(cmd_op), .CMD_DATA(cmd_data[7:0]), .CMD_STEPS(cmd_steps),
    .RSP_VALID(rsp_valid8), .RSP_ERR(rsp_err8), .RSP_DATA(rsp_data8),
    .SERIAL_TX(tx8), .SERIAL_RX(rx8), .LOAD_MODE(load8), .RUN_MODE(run8),
    .OUTPUT_MODE(out8), .DBG_STATE(dbg8)
  );

  grid_serial_host dut64 (
    .CLK(clk), .RESET(reset), .CMD_VALID(cmd_valid & sel), .CMD_READY(ready64),
    .CMD_OP(cmd_op), .CMD_DATA(cmd_data), .CMD_STEPS(cmd_steps),
    .RSP_VALID(rsp_valid64), .RSP_ERR(rsp_err64), .RSP_DATA(rsp_data64),
    .SERIAL_TX(tx64), .SERIAL_RX(rx64), .LOAD_MODE(load64), .RUN_MODE(run64),
    .OUTPUT_MODE(out64), .DBG_STATE(dbg64)
  );

  // Serial memory models: shift in on load, rotate by one per generation,
  // shift out destructively with a one-cycle registered SERIAL_OUT.
  logic [7:0]  mem8 = '0;
  logic [63:0] mem64 = '0;
  logic        so8 = 1'b0;
  logic        so64 = 1'b0;
  assign rx8  = so8;
  assign rx64 = so64;

  always @(posedge clk) begin
    if (load8)     mem8 <= {mem8[6:0], tx8};
    else if (run8) mem8 <= {mem8[6:0], mem8[7]};
    else if (out8) begin
      so8  <= mem8[7];
      mem8 <= {mem8[6:0], 1'b0};
    end
    if (load64)     mem64 <= {mem64[62:0], tx64};
    else if (run64) mem64 <= {mem64[62:0], mem64[63]};
    else if (out64) begin
      so64  <= mem64[63];
      mem64 <= {mem64[62:0], 1'b0};
    end
  end

  logic        w_ready, w_rsp_valid, w_rsp_err, w_tx, w_load, w_run, w_out;
  logic [63:0] w_rsp_data;
  assign w_ready     = sel ? ready64     : ready8;
  assign w_rsp_valid = sel ? rsp_valid64 : rsp_valid8;
  assign w_rsp_err   = sel ? rsp_err64   : rsp_err8;
  assign w_rsp_data  = sel ? rsp_data64  : {56'd0, rsp_data8};
  assign w_tx        = sel ? tx64        : tx8;
  assign w_load      = sel ? load64      : load8;
  assign w_run       = sel ? run64       : run8;
  assign w_out       = sel ? out64       : out8;

  // Command-level reference: grid contents and last read result per host.
  logic [63:0] exp_grid [2];
  logic [63:0] exp_rsp  [2];
  logic [63:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] g, input int r, input int ds);
    logic [63:0] mask;
    mask = (ds == 64) ? '1 : ((64'd1 << ds) - 64'd1);
    if (r == 0) return g & mask;
    return ((g << r) | (g >> (ds - r))) & mask;
  endfunction

  task automatic do_cmd(input bit use64, input logic [1:0] op, input logic [63:0] data,
                        input logic [15:0] steps, input bit junk);
    int ds, idx, wait_c, c, lat, exp_lat;
    int n_load, n_run, n_out, bad_ready, overlap;
    logic [63:0] mask, txv, dm;
    logic got, err_seen, tx_at_rsp;
    logic [63:0] data_seen;
    ds   = use64 ? 64 : 8;
    idx  = use64 ? 1 : 0;
    mask = use64 ? '1 : 64'hFF;
    dm   = data & mask;
    sel  = use64;
    wait_c = 0;
    while (!w_ready && wait_c < 200) begin
      @(negedge clk);
      wait_c++;
    end
    check_eq("ready_wait", w_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_steps = steps;
    @(negedge clk);
    n_load = 0; n_run = 0; n_out = 0; bad_ready = 0; overlap = 0;
    txv = '0; got = 1'b0; lat = 0; err_seen = 1'b0; data_seen = '0; tx_at_rsp = 1'b0;
    c = 1;
    while (c <= 200 && !got) begin
      if (junk) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = {$urandom, $urandom};
        cmd_steps = 16'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      n_load += int'(w_load);
      n_run  += int'(w_run);
      n_out  += int'(w_out);
      if (int'(w_load) + int'(w_run) + int'(w_out) > 1) overlap++;
      if (w_ready) bad_ready++;
      if (w_load) txv = {txv[62:0], w_tx};
      if (w_rsp_valid) begin
        got = 1'b1; lat = c; err_seen = w_rsp_err; data_seen = w_rsp_data; tx_at_rsp = w_tx;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    cmd_valid = 1'b0;

    case (op)
      2'b00: exp_lat = ds + 1;
      2'b01: exp_lat = (steps == 0) ? 1 : int'(steps) + 1;
      2'b10: exp_lat = ds + 2;
      default: exp_lat = 1;
    endcase
    if (op == 2'b10) begin
      exp_rsp[idx]  = exp_grid[idx];
      exp_grid[idx] = '0;
    end else if (op == 2'b00) begin
      exp_grid[idx] = dm;
    end else if (op == 2'b01) begin
      exp_grid[idx] = rotl(exp_grid[idx], int'(steps) % ds, ds);
    end
    exp_q.push_back(exp_rsp[idx]);

    check_eq("rsp_seen", got, 1'b1);
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("rsp_err", err_seen, (op == 2'b11));
    check_eq("rsp_data", data_seen, exp_q.pop_front());
    check_eq("load_cycles", 64'(n_load), (op == 2'b00) ? 64'(ds) : 64'd0);
    check_eq("run_cycles", 64'(n_run), (op == 2'b01) ? 64'(steps) : 64'd0);
    check_eq("out_cycles", 64'(n_out), (op == 2'b10) ? 64'(ds) : 64'd0);
    check_eq("mode_overlap", 64'(overlap), 64'd0);
    check_eq("ready_busy", 64'(bad_ready), 64'd0);
    check_eq("tx_idle", tx_at_rsp, 1'b0);
    if (op == 2'b00) check_eq("tx_bits", txv & mask, dm);
    @(negedge clk);
    check_eq("ready_after", w_ready, 1'b1);
    check_eq("rsp_pulse", w_rsp_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    logic [1:0] op;
    int rc;
    exp_grid[0] = '0; exp_grid[1] = '0;
    exp_rsp[0]  = '0; exp_rsp[1]  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ready", ready8, 1'b0);
    check_eq("rst_modes", {load8, run8, out8, tx8}, 4'b0);
    check_eq("rst_rsp", {rsp_valid8, rsp_err8}, 2'b0);
    check_eq("rst_data", rsp_data8, 8'h00);
    check_eq("rst_state", dbg8, 3'd0);
    reset = 1'b0;
    check_eq("ready_pre_edge", ready8, 1'b0);
    @(negedge clk);
    check_eq("ready_first_edge", ready8, 1'b1);

    // Directed scenarios
    do_cmd(0, 2'b00, 64'hA5, 16'd0, 0);
    check_eq("mem_after_load", mem8, 8'hA5);
    do_cmd(0, 2'b00, 64'h3C, 16'd0, 0);
    do_cmd(0, 2'b10, 64'h0,  16'd0, 0);
    do_cmd(0, 2'b10, 64'h0,  16'd0, 0);
    do_cmd(0, 2'b00, 64'h81, 16'd0, 0);
    do_cmd(0, 2'b01, 64'h0,  16'd3, 0);
    do_cmd(0, 2'b01, 64'h0,  16'd0, 0);
    do_cmd(0, 2'b11, 64'hFF, 16'd5, 0);
    do_cmd(0, 2'b00, 64'h96, 16'd0, 1);
    do_cmd(0, 2'b10, 64'h0,  16'd0, 0);
    do_cmd(0, 2'b00, 64'h5A, 16'd0, 0);
    do_cmd(0, 2'b10, 64'h0,  16'd0, 0);

    // Reset in the middle of a load
    sel = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 64'hFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midload_active", load8, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_load", load8, 1'b0);
    check_eq("abort_tx", tx8, 1'b0);
    check_eq("abort_rsp", {rsp_valid8, rsp_err8}, 2'b0);
    check_eq("abort_data", rsp_data8, 8'h00);
    check_eq("abort_ready", ready8, 1'b0);
    exp_rsp[0] = '0; exp_rsp[1] = '0;
    repeat (2) @(negedge clk);
    check_eq("abort_no_rsp", rsp_valid8, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_release", ready8, 1'b1);

    // Random command mix; first op reloads the partially loaded memory
    for (int i = 0; i < 40; i++) begin
      rc = $urandom_range(0, 9);
      op = (rc < 3) ? 2'b00 : (rc < 6) ? 2'b01 : (rc < 9) ? 2'b10 : 2'b11;
      if (i == 0) op = 2'b00;
      do_cmd(0, op, {$urandom, $urandom}, 16'($urandom_range(0, 12)),
             bit'($urandom_range(0, 1)));
    end

    // Full-width host
    do_cmd(1, 2'b00, 64'h8000_0000_0000_0001, 16'd0, 0);
    do_cmd(1, 2'b10, 64'h0, 16'd0, 0);
    do_cmd(1, 2'b00, {$urandom, $urandom}, 16'd0, 0);
    do_cmd(1, 2'b01, 64'h0, 16'($urandom_range(1, 20)), 0);
    do_cmd(1, 2'b10, 64'h0, 16'd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
